// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Produces truncated BCD digits, an exact overflow flag and a leading-zero mask.
//
// state | meaning
// IDLE  | waiting for start_i, last result held on the outputs
// SHIFT | one add-3/shift step per cycle, count_q steps remaining
module bin2bcd_seq #(
   parameter int W      = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [W-1:0]          bin_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [4*DIGITS-1:0]   bcd_o,
   output logic [DIGITS-1:0]     lz_o,
   output logic                  ovf_o
);

   localparam int CW = $clog2(W + 1);
   localparam int BW = 4 * DIGITS;
   localparam logic [CW-1:0] W_CNT = CW'(W);

   typedef enum logic [0:0] {IDLE, SHIFT} state_t;

   state_t          state_q;
   logic [CW-1:0]   count_q;
   logic [W-1:0]    sh_q, sh_d;
   logic [BW-1:0]   work_q, work_d, adj;
   logic            acc_q, acc_d;
   logic            busy_q, done_q, ovf_q;
   logic [BW-1:0]   bcd_q;
   logic [DIGITS-1:0] lz_q, lz_d;
   logic            zero_above;

   // Digits are adjusted independently; no carry crosses a digit boundary.
   always_comb begin
      adj = work_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (work_q[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
      work_d = {adj[BW-2:0], sh_q[W-1]};
      sh_d   = {sh_q[W-2:0], 1'b0};
      acc_d  = acc_q | adj[BW-1];
      lz_d       = '0;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_above = zero_above & (work_d[4*i +: 4] == 4'd0);
         lz_d[i]    = zero_above;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         count_q <= '0;
         sh_q    <= '0;
         work_q  <= '0;
         acc_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         bcd_q   <= '0;
         lz_q    <= '0;
         ovf_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  sh_q    <= bin_i;
                  work_q  <= '0;
                  acc_q   <= 1'b0;
                  count_q <= W_CNT;
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               sh_q    <= sh_d;
               work_q  <= work_d;
               acc_q   <= acc_d;
               count_q <= count_q - CW'(1);
               if (count_q == CW'(1)) begin
                  bcd_q   <= work_d;
                  ovf_q   <= acc_d;
                  lz_q    <= lz_d;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign bcd_o  = bcd_q;
   assign lz_o   = lz_q;
   assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: three parameterisations checked every cycle against an
// arithmetic model, plus directed conversions with literal expected results.
module tb_bin2bcd_seq;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        st0 = 1'b0, st1 = 1'b0, st2 = 1'b0;
   logic [7:0]  bn0 = '0, bn1 = '0;
   logic [15:0] bn2 = '0;

   logic        busy0, busy1, busy2, done0, done1, done2, ovf0, ovf1, ovf2;
   logic [11:0] bcd0;
   logic [7:0]  bcd1;
   logic [19:0] bcd2;
   logic [2:0]  lz0;
   logic [1:0]  lz1;
   logic [4:0]  lz2;

   bin2bcd_seq #(.W(8), .DIGITS(3)) u0 (
      .clk_i(clk), .rst_i(rst), .start_i(st0), .bin_i(bn0),
      .busy_o(busy0), .done_o(done0), .bcd_o(bcd0), .lz_o(lz0), .ovf_o(ovf0));
   bin2bcd_seq #(.W(8), .DIGITS(2)) u1 (
      .clk_i(clk), .rst_i(rst), .start_i(st1), .bin_i(bn1),
      .busy_o(busy1), .done_o(done1), .bcd_o(bcd1), .lz_o(lz1), .ovf_o(ovf1));
   bin2bcd_seq #(.W(16), .DIGITS(5)) u2 (
      .clk_i(clk), .rst_i(rst), .start_i(st2), .bin_i(bn2),
      .busy_o(busy2), .done_o(done2), .bcd_o(bcd2), .lz_o(lz2), .ovf_o(ovf2));

   logic        busy_w[3], done_w[3], ovf_w[3];
   logic [39:0] bcd_w[3];
   logic [9:0]  lz_w[3];
   always_comb begin
      busy_w[0] = busy0; busy_w[1] = busy1; busy_w[2] = busy2;
      done_w[0] = done0; done_w[1] = done1; done_w[2] = done2;
      ovf_w[0]  = ovf0;  ovf_w[1]  = ovf1;  ovf_w[2]  = ovf2;
      bcd_w[0]  = {28'b0, bcd0}; bcd_w[1] = {32'b0, bcd1}; bcd_w[2] = {20'b0, bcd2};
      lz_w[0]   = {7'b0, lz0};   lz_w[1]  = {8'b0, lz1};   lz_w[2]  = {5'b0, lz2};
   end

   int Wp[3] = '{8, 8, 16};
   int Dp[3] = '{3, 2, 5};

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input int k, input logic [39:0] act, input logic [39:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] got=%h want=%h at %0t", nm, k, act, exp, $time);
      end
   endtask

   // Reference result from plain decimal arithmetic.
   task automatic expect_res(input longint v, input int d, output logic [39:0] b,
                             output logic [9:0] l, output logic o);
      longint p = 1;
      bit zero = 1'b1;
      logic [3:0] dg[10];
      b = '0;
      l = '0;
      for (int i = 0; i < d; i++) begin
         dg[i] = 4'((v / p) % 10);
         b[4*i +: 4] = dg[i];
         p = p * 10;
      end
      o = (v >= p);
      for (int i = d - 1; i >= 1; i--) begin
         zero = zero && (dg[i] == 4'd0);
         l[i] = zero;
      end
   endtask

   function automatic logic get_start(input int k);
      case (k)
         0: return st0;
         1: return st1;
         default: return st2;
      endcase
   endfunction

   function automatic longint get_bin(input int k);
      case (k)
         0: return longint'(bn0);
         1: return longint'(bn1);
         default: return longint'(bn2);
      endcase
   endfunction

   task automatic set_in(input int k, input int v, input logic s);
      case (k)
         0: begin bn0 = 8'(v); st0 = s; end
         1: begin bn1 = 8'(v); st1 = s; end
         default: begin bn2 = 16'(v); st2 = s; end
      endcase
   endtask

   task automatic set_start(input int k, input logic s);
      case (k)
         0: st0 = s;
         1: st1 = s;
         default: st2 = s;
      endcase
   endtask

   logic        m_busy[3], m_done[3], m_ovf[3];
   logic [39:0] m_bcd[3];
   logic [9:0]  m_lz[3];
   int          m_rem[3];
   longint      m_val[3];

   // Model: a conversion takes W cycles, result computed arithmetically at the end.
   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            m_busy[k] = 1'b0; m_done[k] = 1'b0; m_ovf[k] = 1'b0;
            m_bcd[k] = '0; m_lz[k] = '0; m_rem[k] = 0; m_val[k] = 0;
         end else begin
            m_done[k] = 1'b0;
            if (m_busy[k]) begin
               m_rem[k]--;
               if (m_rem[k] == 0) begin
                  m_busy[k] = 1'b0;
                  m_done[k] = 1'b1;
                  expect_res(m_val[k], Dp[k], m_bcd[k], m_lz[k], m_ovf[k]);
               end
            end else if (get_start(k)) begin
               m_val[k]  = get_bin(k);
               m_rem[k]  = Wp[k];
               m_busy[k] = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if ($time > 5) begin
         for (int k = 0; k < 3; k++) begin
            chk("busy", k, 40'(busy_w[k]), 40'(m_busy[k]));
            chk("done", k, 40'(done_w[k]), 40'(m_done[k]));
            chk("bcd",  k, bcd_w[k], m_bcd[k]);
            chk("lz",   k, 40'(lz_w[k]), 40'(m_lz[k]));
            chk("ovf",  k, 40'(ovf_w[k]), 40'(m_ovf[k]));
            chk("busy_and_done", k, 40'(busy_w[k] & done_w[k]), 40'd0);
         end
      end
   end

   // One conversion; optional poke applies bin=250/start=1 mid-conversion.
   task automatic run(input int k, input int v, input logic [39:0] xb,
                      input logic [9:0] xl, input logic xo, input int poke_n);
      int n = 0;
      int bcnt = 0;
      bit got = 1'b0;
      @(negedge clk);
      set_in(k, v, 1'b1);
      while (!got && n < 60) begin
         @(negedge clk);
         n++;
         if (n == 1) set_start(k, 1'b0);
         if (poke_n != 0 && n == poke_n) set_in(k, 250, 1'b1);
         if (poke_n != 0 && n == poke_n + 1) set_start(k, 1'b0);
         if (busy_w[k]) bcnt++;
         if (done_w[k]) got = 1'b1;
      end
      chk("latency", k, 40'(n), 40'(Wp[k] + 1));
      chk("busy_cycles", k, 40'(bcnt), 40'(Wp[k]));
      chk("lit_bcd", k, bcd_w[k], xb);
      chk("lit_lz", k, 40'(lz_w[k]), 40'(xl));
      chk("lit_ovf", k, 40'(ovf_w[k]), 40'(xo));
   endtask

   initial begin
      int n;
      int d1, d2, ndone;
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy", 0, 40'(busy_w[0]), 40'd0);
      chk("rst_bcd", 2, bcd_w[2], 40'd0);
      #2 rst = 1'b0;

      run(0, 255, 40'h255, 10'b000, 1'b0, 0);
      run(0, 0,   40'h000, 10'b110, 1'b0, 0);
      run(0, 99,  40'h099, 10'b100, 1'b0, 0);
      run(0, 7,   40'h007, 10'b110, 1'b0, 0);
      run(1, 99,  40'h99, 10'b00, 1'b0, 0);
      run(1, 100, 40'h00, 10'b10, 1'b1, 0);
      run(1, 200, 40'h00, 10'b10, 1'b1, 0);
      run(1, 123, 40'h23, 10'b00, 1'b1, 0);
      run(2, 65535, 40'h65535, 10'b00000, 1'b0, 0);
      run(2, 1000,  40'h01000, 10'b10000, 1'b0, 0);
      run(0, 42, 40'h042, 10'b100, 1'b0, 3);

      // start held high across done: back-to-back conversions W+1 apart
      @(negedge clk);
      set_in(0, 10, 1'b1);
      n = 0; d1 = 0; d2 = 0;
      while (d2 == 0 && n < 60) begin
         @(negedge clk);
         n++;
         if (done_w[0]) begin
            if (d1 == 0) d1 = n;
            else d2 = n;
         end
      end
      set_start(0, 1'b0);
      chk("done_spacing", 0, 40'(d2 - d1), 40'd9);
      chk("hold_bcd", 0, bcd_w[0], 40'h010);
      n = 0;
      while (busy_w[0] && n < 30) begin @(negedge clk); n++; end
      chk("hold_idle", 0, 40'(busy_w[0]), 40'd0);

      // reset mid-conversion discards the partial result
      @(negedge clk);
      set_in(0, 200, 1'b1);
      @(negedge clk);
      set_start(0, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", 0, 40'(busy_w[0]), 40'd0);
      chk("arst_done", 0, 40'(done_w[0]), 40'd0);
      chk("arst_bcd", 0, bcd_w[0], 40'd0);
      chk("arst_lz", 0, 40'(lz_w[0]), 40'd0);
      chk("arst_ovf", 0, 40'(ovf_w[0]), 40'd0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      ndone = 0;
      repeat (12) begin
         @(negedge clk);
         if (done_w[0]) ndone++;
      end
      chk("post_rst_nodone", 0, 40'(ndone), 40'd0);
      chk("post_rst_bcd", 0, bcd_w[0], 40'd0);

      run(0, 57, 40'h057, 10'b100, 1'b0, 0);
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Parametrised sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It takes a W-bit unsigned value on a start strobe and produces DIGITS packed BCD digits after W clock cycles. It also flags overflow when the value does not fit in DIGITS digits, and produces a leading-zero mask for display blanking. It sits between arithmetic/counter logic and the seven-segment display drivers, and replaces the fixed 8-bit combinational converter where width or area matters.

## Interface
- W, 8, width of the binary input; legal range 4..32
- DIGITS, 3, number of BCD output digits; legal range 1..10
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request a conversion of `bin`; sampled only while `busy`=0
- bin  input  W  unsigned binary operand; sampled on the accepting edge only
- busy  output  1  conversion in progress
- done  output  1  one-cycle pulse: `bcd`/`lz`/`ovf` just updated
- bcd  output  4*DIGITS  packed result; digit i at bits [4i+3:4i], digit 0 = units
- lz  output  DIGITS  bit i=1 when digit i is a leading zero; bit 0 is always 0
- ovf  output  1  1 when bin ≥ 10^DIGITS for the last result

## Operation
- States: IDLE, SHIFT.
- IDLE, start=1: latch `bin` into the shift register, clear the working BCD register and the overflow accumulator, set count=W, go to SHIFT, busy=1.
- IDLE, start=0: hold.
- SHIFT, each cycle:
  - Add 3 to every working digit that is ≥5.
  - Shift {working BCD, shift register} left by 1.
  - OR the bit leaving the top digit's MSB into the overflow accumulator.
  - Decrement count.
- SHIFT, last cycle (count=1): the edge that performs the final shift also:
  - loads `bcd` with the final working value, `ovf` with the accumulator, and `lz` from the final digits;
  - pulses `done`, clears `busy`, and returns to IDLE.
- Overflow: `bcd` holds bin mod 10^DIGITS, because lower digits never depend on higher ones. `ovf` is exact: it is 1 iff any bit was shifted out of the top digit.
- Leading zeros: lz[i]=1 iff digit i and every higher digit are 0, for i≥1. lz[0]=0 always. When ovf=1, lz is computed on the truncated digits as stored.
- `bcd`, `lz`, `ovf` change only on a done edge. They hold the previous result throughout a conversion.
- start while busy=1 is ignored; no queueing.
- Width rules:
  - Working register is 4*DIGITS bits; shift register is W bits; count is $clog2(W+1) bits.
  - Add-3 is a 4-bit add with no carry between digits.

## Timing
- Reset values: busy=0, done=0, bcd=0, lz=0, ovf=0, state IDLE, count=0.
- Latency: start accepted at edge t. busy=1 after edge t. done=1 and results valid after edge t+W. done=0 and busy=0 after edge t+W+1 unless restarted.
- Throughput: one conversion per W+1 cycles at most (one IDLE cycle is required to accept the next start). start held high continuously therefore restarts on the cycle after each done pulse.
- done and busy are never high in the same cycle.
- rst asserted mid-conversion: immediate return to reset values, and the partial result is discarded. The first start after rst deasserts is accepted normally.
- `bin` may change freely after the accepting edge.

## Test plan
- W=8, DIGITS=3, bin=255, one start pulse -> busy high 8 cycles; done after edge t+8; bcd=12'h255, lz=3'b000, ovf=0.
- W=8, DIGITS=3: bin=0 -> bcd=12'h000, lz=3'b110. bin=99 -> bcd=12'h099, lz=3'b100. bin=7 -> bcd=12'h007, lz=3'b110. All with ovf=0.
- W=8, DIGITS=2: bin=99 -> 8'h99, ovf=0. bin=100 -> 8'h00, ovf=1, lz=2'b10. bin=200 -> 8'h00, ovf=1. bin=123 -> 8'h23, ovf=1.
- W=16, DIGITS=5: bin=65535 -> bcd=20'h65535 after 16 cycles. bin=1000 -> 20'h01000, lz=5'b10000.
- Handshake, W=8, DIGITS=3:
  - bin=42, start; mid-conversion bin=250 with start=1 -> ignored, result 12'h042.
  - start held high across the done cycle -> next conversion accepted the cycle after done, so done pulses are 9 cycles apart.
- Reset: start bin=200, assert rst at cycle 4 -> all outputs 0 at once; bcd stays 0 with no done pulse. After release, bin=57 -> 12'h057.
